// File: rtl/shift_pkg.sv
// Shared encodings for the multi-mode shift register: shift modes,
// controller states and the per-bit next-value select of the step cell.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSR = 2'b00,
        SH_ASR = 2'b01,
        SH_LSL = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_t;

    // "from left" takes the neighbour at the next higher index (right shift),
    // "from right" takes the neighbour at the next lower index (left shift).
    typedef enum logic [1:0] {
        SEL_HOLD       = 2'b00,
        SEL_LOAD       = 2'b01,
        SEL_FROM_LEFT  = 2'b10,
        SEL_FROM_RIGHT = 2'b11
    } cell_sel_t;

endpackage

// File: rtl/shift_step_cell.sv
// One bit of the shift register: 4:1 next-value mux plus async-clear flop.
module shift_step_cell
    import shift_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  cell_sel_t sel,
    input  logic      load_bit,
    input  logic      left_bit,
    input  logic      right_bit,
    output logic      q
);

    logic q_next;

    // Select the bit's next value from hold, parallel load or a neighbour.
    always_comb begin
        q_next = q;
        case (sel)
            SEL_LOAD:       q_next = load_bit;
            SEL_FROM_LEFT:  q_next = left_bit;
            SEL_FROM_RIGHT: q_next = right_bit;
            default:        q_next = q;
        endcase
    end

    // Storage flop, cleared by the active-low asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= 1'b0;
        else      q <= q_next;
    end

endmodule

// File: rtl/multi_mode_shift_register.sv
// Multi-mode shift register: load a word, then shift it one position per
// clock in LSR/ASR/LSL/ROR mode for a requested (saturated) count.
// Optional feature macro: SHIFT_STICKY_EN adds the sticky output and flop.
//
// state    | meaning
// ST_IDLE  | accepts ld (priority) or start; out held otherwise
// ST_SHIFT | busy, one shift step and count decrement per cycle
// ST_DONE  | one-cycle done pulse, out stable, inputs ignored
module multi_mode_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
`ifdef SHIFT_STICKY_EN
    ,
    output logic             sticky
`endif
);

    shift_state_t     state, state_next;
    shift_mode_t      mode_q;
    logic [AMT_W-1:0] count;
    logic [AMT_W-1:0] amt_sat;
    cell_sel_t        cell_sel;
    logic             msb_in;
    logic             accept_start;

    assign amt_sat      = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;
    assign accept_start = (state == ST_IDLE) && !ld && start;
    assign busy         = (state == ST_SHIFT);
    assign done         = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next-state decode; a zero count skips straight to the done pulse.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept_start)
                    state_next = (amt_sat == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (count == AMT_W'(1)) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Count and mode are captured on an accepted start; count steps down while shifting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            mode_q <= SH_LSR;
        end else if (accept_start) begin
            count  <= amt_sat;
            mode_q <= shift_mode_t'(mode);
        end else if (state == ST_SHIFT) begin
            count  <= count - AMT_W'(1);
        end
    end

    // Per-bit select and the bit entering at the MSB end for right-going modes.
    always_comb begin
        cell_sel = SEL_HOLD;
        if (state == ST_IDLE && ld)
            cell_sel = SEL_LOAD;
        else if (state == ST_SHIFT)
            cell_sel = (mode_q == SH_LSL) ? SEL_FROM_RIGHT : SEL_FROM_LEFT;

        msb_in = 1'b0;
        case (mode_q)
            SH_ASR:  msb_in = out[WIDTH-1];
            SH_ROR:  msb_in = out[0];
            default: msb_in = 1'b0;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic l_bit;
        logic r_bit;

        if (i == WIDTH - 1) begin : g_top
            assign l_bit = msb_in;
        end else begin : g_mid_l
            assign l_bit = out[i+1];
        end

        if (i == 0) begin : g_bot
            assign r_bit = 1'b0;
        end else begin : g_mid_r
            assign r_bit = out[i-1];
        end

        shift_step_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .sel      (cell_sel),
            .load_bit (in[i]),
            .left_bit (l_bit),
            .right_bit(r_bit),
            .q        (out[i])
        );
    end

`ifdef SHIFT_STICKY_EN
    // Sticky collects bits falling off bit 0 in the right-shifting, non-rotating modes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sticky <= 1'b0;
        else if (state == ST_IDLE && (ld || start))
            sticky <= 1'b0;
        else if (state == ST_SHIFT && (mode_q == SH_LSR || mode_q == SH_ASR))
            sticky <= sticky | out[0];
    end
`endif

endmodule
